// File: rtl/nmi_arbiter.sv
// NMI arbiter: latches magic/pause/divMMC/soft requests, grants one per ULA frame edge,
// holds n_nmi until the CPU fetches the 0x0066 vector or the hold timer expires.
module nmi_arbiter #(
    parameter int unsigned HOLD_MAX = 8192,
    parameter int unsigned COOLDOWN = 64
) (
    input  logic        clk28,
    input  logic        rst,
    input  logic [15:0] bus_a,
    input  logic        bus_mreq,
    input  logic        bus_m1,
    input  logic        n_int,
    input  logic        n_int_next,
    input  logic [3:0]  req,
    input  logic [3:0]  mask,
    input  logic        busy,
    output logic        n_nmi,
    output logic [1:0]  grant_src,
    output logic        grant_valid,
    output logic        ack,
    output logic        timeout
);

    localparam int unsigned HOLD_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam int unsigned COOL_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);
    localparam logic [COOL_W-1:0] COOL_LAST = COOL_W'(COOLDOWN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ASSERT,
        S_COOL
    } state_t;

    state_t            state, state_d;
    logic [3:0]        pending, pending_d;
    logic [3:0]        req_prev;
    logic [3:0]        clr;
    logic [HOLD_W-1:0] hold_cnt, hold_d;
    logic [COOL_W-1:0] cool_cnt, cool_d;
    logic              n_nmi_d, grant_valid_d, ack_d, timeout_d;
    logic [1:0]        grant_src_d;
    logic [1:0]        pick_idx;
    logic [3:0]        pick_onehot;
    logic              fe, ack_hit;

    assign fe      = n_int && !n_int_next;
    assign ack_hit = bus_m1 && bus_mreq && (bus_a == 16'h0066);

    // Fixed priority: lowest index (magic) wins
    always_comb begin
        pick_idx    = 2'd0;
        pick_onehot = 4'b0000;
        if (pending[0]) begin
            pick_idx    = 2'd0;
            pick_onehot = 4'b0001;
        end else if (pending[1]) begin
            pick_idx    = 2'd1;
            pick_onehot = 4'b0010;
        end else if (pending[2]) begin
            pick_idx    = 2'd2;
            pick_onehot = 4'b0100;
        end else if (pending[3]) begin
            pick_idx    = 2'd3;
            pick_onehot = 4'b1000;
        end
    end

    // A fresh rising edge beats a same-cycle grant clear; masked sources are dropped
    always_comb begin
        pending_d = ((pending & ~clr) | (req & ~req_prev & mask)) & mask;
    end

    always_comb begin
        state_d       = state;
        hold_d        = hold_cnt;
        cool_d        = cool_cnt;
        n_nmi_d       = n_nmi;
        grant_src_d   = grant_src;
        grant_valid_d = grant_valid;
        ack_d         = 1'b0;
        timeout_d     = 1'b0;
        clr           = 4'b0000;
        case (state)
            S_IDLE: begin
                if (|pending) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (pending == 4'b0000) begin
                    state_d = S_IDLE;
                end else if (fe && !busy) begin
                    grant_src_d   = pick_idx;
                    clr           = pick_onehot;
                    n_nmi_d       = 1'b0;
                    grant_valid_d = 1'b1;
                    hold_d        = '0;
                    state_d       = S_ASSERT;
                end
            end
            S_ASSERT: begin
                if (ack_hit) begin
                    n_nmi_d       = 1'b1;
                    grant_valid_d = 1'b0;
                    ack_d         = 1'b1;
                    cool_d        = '0;
                    state_d       = S_COOL;
                end else if (hold_cnt == HOLD_LAST) begin
                    n_nmi_d       = 1'b1;
                    grant_valid_d = 1'b0;
                    timeout_d     = 1'b1;
                    cool_d        = '0;
                    state_d       = S_COOL;
                end else begin
                    hold_d = hold_cnt + HOLD_W'(1);
                end
            end
            S_COOL: begin
                if (cool_cnt == COOL_LAST) begin
                    state_d = (|pending) ? S_WAIT : S_IDLE;
                end else begin
                    cool_d = cool_cnt + COOL_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // req_prev resets to all-ones so levels held through reset never count as edges
    always_ff @(posedge clk28) begin
        if (rst) begin
            state       <= S_IDLE;
            pending     <= 4'b0000;
            req_prev    <= 4'b1111;
            hold_cnt    <= '0;
            cool_cnt    <= '0;
            n_nmi       <= 1'b1;
            grant_src   <= 2'd0;
            grant_valid <= 1'b0;
            ack         <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_d;
            pending     <= pending_d;
            req_prev    <= req;
            hold_cnt    <= hold_d;
            cool_cnt    <= cool_d;
            n_nmi       <= n_nmi_d;
            grant_src   <= grant_src_d;
            grant_valid <= grant_valid_d;
            ack         <= ack_d;
            timeout     <= timeout_d;
        end
    end

endmodule

// File: tb/tb_nmi_arbiter.sv
// Bench for nmi_arbiter: directed scenarios plus a randomized run against a behavioural model.
module tb_nmi_arbiter;

    localparam int unsigned HOLD  = 100;
    localparam int unsigned COOL  = 16;
    localparam int unsigned FRAME = 300;

    logic        clk28 = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] bus_a = 16'h0000;
    logic        bus_mreq = 1'b0;
    logic        bus_m1 = 1'b0;
    logic        n_int = 1'b1;
    logic        n_int_next = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic [3:0]  mask = 4'b1111;
    logic        busy = 1'b0;
    logic        n_nmi;
    logic [1:0]  grant_src;
    logic        grant_valid;
    logic        ack;
    logic        timeout;

    int n_pass = 0;
    int n_total = 0;
    int fc = 50;

    nmi_arbiter #(.HOLD_MAX(HOLD), .COOLDOWN(COOL)) dut (
        .clk28(clk28), .rst(rst), .bus_a(bus_a), .bus_mreq(bus_mreq), .bus_m1(bus_m1),
        .n_int(n_int), .n_int_next(n_int_next), .req(req), .mask(mask), .busy(busy),
        .n_nmi(n_nmi), .grant_src(grant_src), .grant_valid(grant_valid),
        .ack(ack), .timeout(timeout)
    );

    always #5 clk28 = ~clk28;

    // Frame generator: n_int_next low for 8 cycles from fc==0, n_int one cycle later
    always @(posedge clk28) begin
        #2;
        fc = (fc + 1) % FRAME;
        n_int_next = !(fc < 8);
        n_int      = !(fc >= 1 && fc < 9);
    end

    // Reference model: pending set, armed waiting for a frame, NMI on, cooldown remaining
    logic [3:0] m_req_prev = 4'b1111;
    logic [3:0] m_pend = 4'b0000;
    bit         m_armed = 1'b0;
    bit         m_on = 1'b0;
    int         m_hold = 0;
    int         m_cool = 0;
    logic [1:0] m_src = 2'd0;
    bit         m_ack = 1'b0;
    bit         m_to = 1'b0;

    always @(posedge clk28) begin : model
        logic [3:0] rise, clr;
        bit fe_now, hit;
        int idx;
        if (rst) begin
            m_req_prev = 4'b1111; m_pend = 4'b0000; m_armed = 0; m_on = 0;
            m_hold = 0; m_cool = 0; m_src = 2'd0; m_ack = 0; m_to = 0;
        end else begin
            rise = req & ~m_req_prev;
            clr = 4'b0000;
            m_ack = 0;
            m_to = 0;
            fe_now = n_int && !n_int_next;
            hit = bus_m1 && bus_mreq && (bus_a == 16'h0066);
            if (m_on) begin
                if (hit) begin
                    m_on = 0; m_ack = 1; m_cool = COOL;
                end else if (m_hold == int'(HOLD) - 1) begin
                    m_on = 0; m_to = 1; m_cool = COOL;
                end else begin
                    m_hold++;
                end
            end else if (m_cool > 0) begin
                m_cool--;
                if (m_cool == 0) m_armed = (m_pend != 0);
            end else if (m_armed) begin
                if (m_pend == 0) begin
                    m_armed = 0;
                end else if (fe_now && !busy) begin
                    idx = 0;
                    for (int i = 3; i >= 0; i--) if (m_pend[i]) idx = i;
                    m_src = 2'(idx);
                    clr = 4'b0001 << idx;
                    m_on = 1; m_hold = 0; m_armed = 0;
                end
            end else if (m_pend != 0) begin
                m_armed = 1;
            end
            m_pend = ((m_pend & ~clr) | (rise & mask)) & mask;
            m_req_prev = req;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk28);
    endtask

    task automatic wait_fe();
        int i;
        bit ok;
        i = 0;
        ok = 0;
        while (!ok && i < int'(FRAME) + 5) begin
            @(negedge clk28);
            ok = n_int && !n_int_next;
            i++;
        end
        if (!ok) begin
            $display("FAIL wait_fe: no frame edge within %0d cycles", FRAME + 5);
            $fatal(1, "frame generator stalled");
        end
    endtask

    task automatic sync_frame();
        wait_fe();
        tick(20);
    endtask

    task automatic do_ack();
        bus_a = 16'h0066; bus_m1 = 1'b1; bus_mreq = 1'b1;
        tick();
        bus_a = 16'h0000; bus_m1 = 1'b0; bus_mreq = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; mask = 4'b1111;
        tick(3);
        n_total++;
        if ({n_nmi, grant_src, grant_valid, ack, timeout} !== 6'b1_00_0_0_0)
            $display("FAIL reset_values: got n_nmi=%b src=%0d valid=%b ack=%b to=%b, want 1 0 0 0 0",
                     n_nmi, grant_src, grant_valid, ack, timeout);
        else n_pass++;
        rst = 1'b0;
        wait_fe();
        tick(3);
        n_total++;
        if (n_nmi !== 1'b1) $display("FAIL reset_held_req: n_nmi=%b want 1", n_nmi);
        else n_pass++;
        req = 4'b0000;
        tick(2);
    endtask

    task automatic test_single();
        int lows;
        sync_frame();
        req = 4'b0001;
        wait_fe();
        n_total++;
        if (n_nmi !== 1'b1) $display("FAIL single_before_edge: n_nmi=%b want 1", n_nmi);
        else n_pass++;
        tick();
        n_total++;
        if ({n_nmi, grant_src, grant_valid} !== 4'b0_00_1)
            $display("FAIL single_grant: n_nmi=%b src=%0d valid=%b want 0 0 1", n_nmi, grant_src, grant_valid);
        else n_pass++;
        tick(5);
        do_ack();
        n_total++;
        if ({n_nmi, ack, grant_valid} !== 3'b1_1_0)
            $display("FAIL single_ack: n_nmi=%b ack=%b valid=%b want 1 1 0", n_nmi, ack, grant_valid);
        else n_pass++;
        tick();
        n_total++;
        if (ack !== 1'b0) $display("FAIL single_ack_pulse: ack=%b want 0", ack);
        else n_pass++;
        lows = 0;
        repeat (2 * FRAME) begin
            tick();
            if (n_nmi !== 1'b1) lows++;
        end
        n_total++;
        if (lows != 0) $display("FAIL single_no_repeat: low cycles=%0d want 0", lows);
        else n_pass++;
        req = 4'b0000;
        tick(2);
    endtask

    task automatic test_priority();
        sync_frame();
        req = 4'b1000;
        tick(5);
        req = 4'b1010;
        wait_fe();
        tick();
        n_total++;
        if ({n_nmi, grant_src} !== 3'b0_01)
            $display("FAIL prio_first: n_nmi=%b src=%0d want 0 1", n_nmi, grant_src);
        else n_pass++;
        tick(3);
        do_ack();
        n_total++;
        if ({n_nmi, ack} !== 2'b11) $display("FAIL prio_first_ack: n_nmi=%b ack=%b want 1 1", n_nmi, ack);
        else n_pass++;
        wait_fe();
        tick();
        n_total++;
        if ({n_nmi, grant_src} !== 3'b0_11)
            $display("FAIL prio_second: n_nmi=%b src=%0d want 0 3", n_nmi, grant_src);
        else n_pass++;
        do_ack();
        req = 4'b0000;
        tick(40);
    endtask

    task automatic test_busy();
        sync_frame();
        busy = 1'b1;
        req = 4'b0001;
        wait_fe();
        tick();
        n_total++;
        if (n_nmi !== 1'b1) $display("FAIL busy_edge1: n_nmi=%b want 1", n_nmi);
        else n_pass++;
        wait_fe();
        tick();
        n_total++;
        if (n_nmi !== 1'b1) $display("FAIL busy_edge2: n_nmi=%b want 1", n_nmi);
        else n_pass++;
        busy = 1'b0;
        wait_fe();
        tick();
        n_total++;
        if ({n_nmi, grant_src} !== 3'b0_00)
            $display("FAIL busy_edge3: n_nmi=%b src=%0d want 0 0", n_nmi, grant_src);
        else n_pass++;
        do_ack();
        req = 4'b0000;
        tick(40);
    endtask

    task automatic test_timeout();
        int cnt;
        int acks;
        sync_frame();
        req = 4'b0100;
        wait_fe();
        tick();
        cnt = 0;
        acks = 0;
        while (n_nmi === 1'b0 && cnt < 200) begin
            if (ack !== 1'b0) acks++;
            cnt++;
            tick();
        end
        n_total++;
        if (cnt != int'(HOLD) || timeout !== 1'b1 || ack !== 1'b0 || acks != 0)
            $display("FAIL timeout_len: low=%0d timeout=%b acks=%0d want %0d 1 0", cnt, timeout, acks + int'(ack), HOLD);
        else n_pass++;
        tick();
        n_total++;
        if (timeout !== 1'b0) $display("FAIL timeout_pulse: timeout=%b want 0", timeout);
        else n_pass++;
        wait_fe();
        tick();
        n_total++;
        if (n_nmi !== 1'b1) $display("FAIL timeout_dropped: n_nmi=%b want 1", n_nmi);
        else n_pass++;
        req = 4'b0000;
        tick(2);
    endtask

    task automatic test_mask();
        sync_frame();
        req = 4'b0100;
        tick(3);
        mask = 4'b1011;
        tick(3);
        wait_fe();
        tick();
        n_total++;
        if (n_nmi !== 1'b1) $display("FAIL mask_clear: n_nmi=%b want 1", n_nmi);
        else n_pass++;
        mask = 4'b1111;
        wait_fe();
        tick();
        n_total++;
        if (n_nmi !== 1'b1) $display("FAIL mask_restore: n_nmi=%b want 1", n_nmi);
        else n_pass++;
        req = 4'b0000;
        tick(2);
    endtask

    task automatic test_rst_assert();
        sync_frame();
        req = 4'b0001;
        wait_fe();
        tick();
        n_total++;
        if (n_nmi !== 1'b0) $display("FAIL rst_assert_grant: n_nmi=%b want 0", n_nmi);
        else n_pass++;
        rst = 1'b1;
        tick();
        n_total++;
        if ({n_nmi, grant_valid, grant_src} !== 4'b1_0_00)
            $display("FAIL rst_assert_release: n_nmi=%b valid=%b src=%0d want 1 0 0", n_nmi, grant_valid, grant_src);
        else n_pass++;
        rst = 1'b0;
        req = 4'b0000;
        tick(3);
    endtask

    task automatic test_collision();
        int i;
        sync_frame();
        req = 4'b0001;
        i = 0;
        while (fc != int'(FRAME) - 1 && i < int'(FRAME) + 5) begin
            tick();
            i++;
        end
        req = 4'b0000;
        tick();
        req = 4'b0001;
        tick();
        n_total++;
        if ({n_nmi, grant_src} !== 3'b0_00)
            $display("FAIL collide_grant: n_nmi=%b src=%0d want 0 0", n_nmi, grant_src);
        else n_pass++;
        do_ack();
        wait_fe();
        tick();
        n_total++;
        if ({n_nmi, grant_src} !== 3'b0_00)
            $display("FAIL collide_second: n_nmi=%b src=%0d want 0 0", n_nmi, grant_src);
        else n_pass++;
        do_ack();
        req = 4'b0000;
        tick(40);
    endtask

    task automatic test_random();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 6000; c++) begin
            tick();
            n_total++;
            if ({n_nmi, grant_valid, grant_src, ack, timeout} !== {!m_on, m_on, m_src, m_ack, m_to})
                $display("FAIL random_cycle %0d: got n_nmi=%b valid=%b src=%0d ack=%b to=%b want %b %b %0d %b %b",
                         c, n_nmi, grant_valid, grant_src, ack, timeout, !m_on, m_on, m_src, m_ack, m_to);
            else n_pass++;
            for (int b = 0; b < 4; b++) if ($urandom_range(63) == 0) req[b] = ~req[b];
            if ($urandom_range(199) == 0) busy = ~busy;
            if ($urandom_range(299) == 0) mask[$urandom_range(3)] ^= 1'b1;
            bus_a    = ($urandom_range(7) == 0) ? 16'h0066 : 16'($urandom);
            bus_m1   = 1'($urandom);
            bus_mreq = 1'($urandom);
            rst      = ($urandom_range(2499) == 0);
        end
        rst = 1'b0; busy = 1'b0; mask = 4'b1111; req = 4'b0000;
        bus_a = 16'h0000; bus_m1 = 1'b0; bus_mreq = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_busy();
        test_timeout();
        test_mask();
        test_rst_assert();
        test_collision();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
